// File: rtl/fifo_pkg.sv
// Shared defaults and the per-port transfer mode for the req/ack FIFO.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 32;
  localparam int FIFO_DEF_DEPTH = 16;

  typedef enum logic {
    FIFO_HANDSHAKE = 1'b0,
    FIFO_STREAM    = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/fifo_ram_2p.sv
// Storage array: one synchronous write port and one asynchronous read port.
module fifo_ram_2p
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_req_ack_resp.sv
// Responding end of the push/pop req/ack handshake: pointers, count and the two
// port controllers around a 2-port RAM. Each port runs handshake or stream mode.
module fifo_req_ack_resp
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_req,
  input  logic [WIDTH-1:0] push_data_in,
  input  logic             push_stream_mode,
  output logic             push_ack,
  output logic             push_ack_pulse,
  output logic             push_fifo_full,
  input  logic             pop_req,
  input  logic             pop_stream_mode,
  output logic             pop_ack,
  output logic             pop_ack_pulse,
  output logic [WIDTH-1:0] pop_data_out,
  output logic             pop_fifo_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake rules (both ports):
  //   handshake mode: a request is taken at an edge where req && !ack && room/data;
  //                   ack is high for exactly the following cycle.
  //   stream mode:    ack is a registered ready/valid; a transfer happens at every
  //                   edge where req && ack.
  fifo_mode_e push_mode, pop_mode;
  assign push_mode = fifo_mode_e'(push_stream_mode);
  assign pop_mode  = fifo_mode_e'(pop_stream_mode);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_raddr;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ack_q, push_ack_d, push_pulse_q, push_pulse_d;
  logic             pop_ack_q, pop_ack_d, pop_pulse_q, pop_pulse_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d, ram_rdata;
  logic             push_commit, pop_commit;

  always_comb begin
    push_commit = 1'b0;
    pop_commit  = 1'b0;
    if (push_req && !full_q) begin
      push_commit = (push_mode == FIFO_STREAM) ? push_ack_q : !push_ack_q;
    end
    if (pop_req && !empty_q) begin
      pop_commit = (pop_mode == FIFO_STREAM) ? pop_ack_q : !pop_ack_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_commit);
    rd_ptr_d = rd_ptr_q + AW'(pop_commit);
    count_d  = count_q + CW'(push_commit) - CW'(pop_commit);
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    push_pulse_d = push_commit;
    pop_pulse_d  = pop_commit;
    push_ack_d = (push_mode == FIFO_STREAM) ? (count_d < DEPTH_C) : push_commit;
    pop_ack_d  = (pop_mode == FIFO_STREAM) ? (count_d != '0) : pop_commit;
  end

  // Stream mode looks ahead to the post-edge head; handshake reads the current head.
  assign ram_raddr = (pop_mode == FIFO_STREAM) ? rd_ptr_d : rd_ptr_q;

  always_comb begin
    pop_data_d = pop_data_q;
    if (pop_mode == FIFO_STREAM) begin
      if (count_d != '0) begin
        // A write landing in the slot that becomes head is not in the RAM yet.
        pop_data_d = (push_commit && (wr_ptr_q == rd_ptr_d)) ? push_data_in : ram_rdata;
      end
    end else if (pop_commit) begin
      pop_data_d = ram_rdata;
    end
  end

  fifo_ram_2p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push_commit && rstn),
    .waddr (wr_ptr_q),
    .wdata (push_data_in),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      push_ack_q   <= 1'b0;
      push_pulse_q <= 1'b0;
      pop_ack_q    <= 1'b0;
      pop_pulse_q  <= 1'b0;
      pop_data_q   <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      push_ack_q   <= push_ack_d;
      push_pulse_q <= push_pulse_d;
      pop_ack_q    <= pop_ack_d;
      pop_pulse_q  <= pop_pulse_d;
      pop_data_q   <= pop_data_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
    end
  end

  assign push_ack       = push_ack_q;
  assign push_ack_pulse = push_pulse_q;
  assign push_fifo_full = full_q;
  assign pop_ack        = pop_ack_q;
  assign pop_ack_pulse  = pop_pulse_q;
  assign pop_data_out   = pop_data_q;
  assign pop_fifo_empty = empty_q;

  push_mode_stable: assert property (@(posedge clk) disable iff (!rstn)
    push_req |-> $stable(push_stream_mode));
  pop_mode_stable: assert property (@(posedge clk) disable iff (!rstn)
    pop_req |-> $stable(pop_stream_mode));

endmodule

// File: tb/tb_fifo_req_ack_resp.sv
// Bench for fifo_req_ack_resp: directed steps plus random traffic, checked against
// a queue-based reference of the FIFO contents and the port ack rules.
module tb_fifo_req_ack_resp;
  import fifo_pkg::*;

  localparam int W = 32;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic         push_req, push_stream_mode, pop_req, pop_stream_mode;
  logic [W-1:0] push_data_in;
  logic         push_ack, push_ack_pulse, push_fifo_full;
  logic         pop_ack, pop_ack_pulse, pop_fifo_empty;
  logic [W-1:0] pop_data_out;

  fifo_req_ack_resp #(.WIDTH(W), .DEPTH(D)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .push_req         (push_req),
    .push_data_in     (push_data_in),
    .push_stream_mode (push_stream_mode),
    .push_ack         (push_ack),
    .push_ack_pulse   (push_ack_pulse),
    .push_fifo_full   (push_fifo_full),
    .pop_req          (pop_req),
    .pop_stream_mode  (pop_stream_mode),
    .pop_ack          (pop_ack),
    .pop_ack_pulse    (pop_ack_pulse),
    .pop_data_out     (pop_data_out),
    .pop_fifo_empty   (pop_fifo_empty)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // reference model state
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic         m_push_ack, m_push_pulse, m_pop_ack, m_pop_pulse, m_pmode;
  logic [W-1:0] m_pop_data;
  logic [W-1:0] sent[$];
  logic [W-1:0] got[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge to the queue model using the inputs present at the edge.
  task automatic model_edge();
    logic         pc, qc;
    logic [W-1:0] popped;
    m_pmode = pop_stream_mode;
    if (!rstn) begin
      exp_q.delete();
      {m_push_ack, m_push_pulse, m_pop_ack, m_pop_pulse} = '0;
      m_pop_data = '0;
      return;
    end
    pc = push_req && (exp_q.size() < D) && (push_stream_mode ? m_push_ack : !m_push_ack);
    qc = pop_req && (exp_q.size() > 0) && (pop_stream_mode ? m_pop_ack : !m_pop_ack);
    if (qc) begin
      popped = exp_q.pop_front();
      if (!pop_stream_mode) m_pop_data = popped;
    end
    if (pc) exp_q.push_back(push_data_in);
    m_push_ack   = push_stream_mode ? (exp_q.size() < D) : pc;
    m_pop_ack    = pop_stream_mode ? (exp_q.size() != 0) : qc;
    m_push_pulse = pc;
    m_pop_pulse  = qc;
    if (pop_stream_mode && exp_q.size() != 0) m_pop_data = exp_q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("push_ack", push_ack, m_push_ack);
    chk("push_ack_pulse", push_ack_pulse, m_push_pulse);
    chk("pop_ack", pop_ack, m_pop_ack);
    chk("pop_ack_pulse", pop_ack_pulse, m_pop_pulse);
    chk("pop_fifo_empty", pop_fifo_empty, exp_q.size() == 0);
    chk("push_fifo_full", push_fifo_full, exp_q.size() == D);
    if (m_pop_ack || !m_pmode) chk("pop_data_out", pop_data_out, m_pop_data);
  endtask

  // driver tasks
  task automatic hs_push(input logic [W-1:0] d);
    int n;
    push_req = 1'b1;
    push_data_in = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_push_ack && n < 8);
    chk("hs_push_acked", push_ack, 1);
    push_req = 1'b0;
    tick();
    chk("hs_push_ack_width", push_ack, 0);
  endtask

  task automatic hs_pop(input logic [W-1:0] d);
    int n;
    pop_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_pop_ack && n < 8);
    chk("hs_pop_acked", pop_ack, 1);
    chk("hs_pop_data", pop_data_out, d);
    pop_req = 1'b0;
    tick();
    chk("hs_pop_ack_width", pop_ack, 0);
  endtask

  initial begin
    int           n, pulses;
    logic         take_push, take_pop;
    logic [W-1:0] expv;

    rstn = 1'b0;
    push_req = 1'b0;
    pop_req = 1'b0;
    push_stream_mode = 1'b0;
    pop_stream_mode = 1'b0;
    push_data_in = '0;
    tick();
    tick();
    chk("rst_empty", pop_fifo_empty, 1);
    chk("rst_full", push_fifo_full, 0);
    chk("rst_pop_data", pop_data_out, 0);
    rstn = 1'b1;
    tick();

    // handshake push/pop of three entries
    hs_push(32'hA1);
    hs_push(32'hA2);
    hs_push(32'hA3);
    hs_pop(32'hA1);
    hs_pop(32'hA2);
    hs_pop(32'hA3);
    chk("hs_end_empty", pop_fifo_empty, 1);

    // stream push 0..15 fills the FIFO with one ack per cycle
    push_stream_mode = 1'b1;
    tick();
    push_req = 1'b1;
    n = 0;
    pulses = 0;
    for (int c = 0; c < 40 && n < D; c++) begin
      push_data_in = W'(n);
      take_push = m_push_ack;
      tick();
      pulses++;
      if (take_push) n++;
    end
    chk("stream_fill_cycles", W'(pulses), W'(D));
    chk("stream_fill_full", push_fifo_full, 1);
    chk("stream_fill_ready", push_ack, 0);
    push_data_in = 32'h99;
    tick();
    chk("stream_17th_pulse", push_ack_pulse, 0);
    chk("stream_17th_full", push_fifo_full, 1);
    push_req = 1'b0;
    push_stream_mode = 1'b0;
    tick();

    // handshake push held at full, released by a handshake pop
    push_req = 1'b1;
    push_data_in = 32'h55;
    tick();
    tick();
    chk("full_hold_ack", push_ack, 0);
    pop_req = 1'b1;
    tick();
    chk("full_pop_data", pop_data_out, 0);
    pop_req = 1'b0;
    n = 0;
    while (!m_push_ack && n < 4) begin
      tick();
      n++;
    end
    chk("full_push_latency_ok", W'(n <= 2), 1);
    chk("full_push_acked", push_ack, 1);
    push_req = 1'b0;
    pop_stream_mode = 1'b1;
    tick();

    // stream drain: contents are 1..15 then 0x55
    pop_req = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < D; c++) begin
      take_pop = m_pop_ack;
      expv = (n < D - 1) ? W'(n + 1) : 32'h55;
      if (take_pop) chk("drain_data", pop_data_out, expv);
      tick();
      if (take_pop) n++;
    end
    chk("drain_count", W'(n), W'(D));
    chk("drain_empty", pop_fifo_empty, 1);

    // empty FIFO, stream pop held, handshake write is bypassed to the head
    tick();
    push_req = 1'b1;
    push_data_in = 32'h77;
    tick();
    chk("bypass_ack", pop_ack, 1);
    chk("bypass_data", pop_data_out, 32'h77);
    push_req = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      pulses += int'(pop_ack_pulse);
    end
    chk("bypass_pulses", W'(pulses), 1);
    pop_req = 1'b0;
    push_stream_mode = 1'b1;
    tick();

    // simultaneous stream push and pop at count 8
    push_req = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      push_data_in = $urandom();
      take_push = m_push_ack;
      if (take_push) sent.push_back(push_data_in);
      tick();
      if (take_push) n++;
    end
    pop_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      push_data_in = $urandom();
      take_push = m_push_ack;
      take_pop = m_pop_ack;
      if (take_push) sent.push_back(push_data_in);
      if (take_pop) got.push_back(pop_data_out);
      tick();
      chk("steady_push_ack", push_ack, 1);
      chk("steady_pop_ack", pop_ack, 1);
    end
    push_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (m_pop_ack) got.push_back(pop_data_out);
      tick();
    end
    pop_req = 1'b0;
    tick();
    chk("order_len", W'(got.size()), W'(sent.size()));
    for (int i = 0; i < got.size() && i < sent.size(); i++) chk("order_data", got[i], sent[i]);

    // random traffic, modes changed only in cycles with the request low
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        push_req = 1'b0;
        push_stream_mode = 1'($urandom_range(0, 1));
      end else begin
        push_req = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 15) == 0) begin
        pop_req = 1'b0;
        pop_stream_mode = 1'($urandom_range(0, 1));
      end else begin
        pop_req = ($urandom_range(0, 3) != 0);
      end
      push_data_in = $urandom();
      tick();
    end

    // reset in the middle of a stream push of 10 entries
    push_req = 1'b0;
    pop_req = 1'b0;
    push_stream_mode = 1'b1;
    pop_stream_mode = 1'b0;
    tick();
    push_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      push_data_in = $urandom();
      tick();
    end
    rstn = 1'b0;
    push_data_in = 32'hDEAD;
    tick();
    chk("midrst_empty", pop_fifo_empty, 1);
    chk("midrst_push_ack", push_ack, 0);
    chk("midrst_pop_ack", pop_ack, 0);
    chk("midrst_pop_data", pop_data_out, 0);
    push_req = 1'b0;
    push_stream_mode = 1'b0;
    rstn = 1'b1;
    tick();
    hs_push(32'hBEEF);
    hs_pop(32'hBEEF);
    chk("post_rst_empty", pop_fifo_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
